match_sequencer: RTL and testbench

Game-flow controller for the Pong scoreboard datapath.
- Turns raw ball-miss events into frame-aligned score-increment pulses and clear pulses for the BCD scoreboard.
- Keeps its own score tallies for match-point detection.
- Sequences serve, play, point-hold and game-over phases.
- Drives ball-control and display-blink outputs.
- Sits between the ball/paddle physics block and the seven-segment scoreboard.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/match_sequencer_frame_timer.sv | 29 ++
 rtl/match_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_match_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-flow control path.
package pong_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } match_state_t;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    // Largest of three frame counts; sizes the shared frame timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/match_sequencer_frame_timer.sv
// Loadable frame-tick down-counter. A reload of N-1 yields done on the
// N-th frame tick after the load; the count parks at zero afterwards.
module frame_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          frame,
    output logic          done
);

    logic [TW-1:0] count;

    // Load has priority over counting so a reload on the expiring tick restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (frame && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = frame && (count == '0);

endmodule

// File: rtl/match_sequencer.sv
// Pong game-flow controller: turns miss events into frame-aligned score
// pulses, keeps match tallies and sequences serve/play/point/game-over.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int HOLD_FRAMES  = 90,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       right_en,
    output logic       left_en,
    output logic       score_clear,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic       blank,
    output logic [6:0] score_right,
    output logic [6:0] score_left
);

    localparam int TW = $clog2(max3(SERVE_FRAMES, HOLD_FRAMES, BLINK_FRAMES)) + 1;
    localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_FRAMES - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_FRAMES - 1);
    localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    WIN_TALLY  = 7'(WIN_SCORE);

    match_state_t  state;
    logic          start_q;
    logic          pending;
    logic          pend_side;
    logic          run_q;
    logic          start_rise;
    logic          point_now;
    logic          let_now;
    logic          win_any;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    assign start_rise = start & ~start_q;
    // A latched point is scored only on a frame so the scoreboard stays frame-aligned.
    assign point_now  = (state == PLAY) && pending && frame && !reset;
    assign let_now    = (state == PLAY) && !pending && miss_left && miss_right;
    assign win_any    = (score_left == WIN_TALLY) || (score_right == WIN_TALLY);

    assign right_en = point_now && (pend_side == SIDE_RIGHT);
    assign left_en  = point_now && (pend_side == SIDE_LEFT);
    // Motion stops in the scoring cycle itself, not a cycle later.
    assign ball_run = run_q && !point_now;

    frame_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .frame    (frame),
        .done     (tmr_done)
    );

    // Timer reload requests for serve delay, point hold and game-over blink.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SERVE_LOAD;
        case (state)
            IDLE: begin
                tmr_load = start_rise;
            end
            PLAY: begin
                if (point_now) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else if (let_now) begin
                    tmr_load = 1'b1;
                end
            end
            POINT: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = win_any ? BLINK_LOAD : SERVE_LOAD;
                end
            end
            OVER: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = BLINK_LOAD;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    // Match FSM with registered control outputs and score tallies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            start_q     <= 1'b0;
            pending     <= 1'b0;
            pend_side   <= SIDE_LEFT;
            run_q       <= 1'b0;
            score_clear <= 1'b1;
            ball_center <= 1'b1;
            serve_dir   <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            blank       <= 1'b0;
            score_right <= '0;
            score_left  <= '0;
        end else begin
            start_q <= start;
            case (state)
                CLEAR: begin
                    score_clear <= 1'b1;
                    ball_center <= 1'b1;
                    if (frame) begin
                        score_clear <= 1'b0;
                        state       <= IDLE;
                    end
                end
                IDLE: begin
                    if (start_rise) begin
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (tmr_done) begin
                        state       <= PLAY;
                        ball_center <= 1'b0;
                        run_q       <= 1'b1;
                    end
                end
                PLAY: begin
                    if (point_now) begin
                        pending     <= 1'b0;
                        run_q       <= 1'b0;
                        ball_center <= 1'b1;
                        state       <= POINT;
                        if (pend_side == SIDE_RIGHT) begin
                            score_right <= score_right + 7'd1;
                            serve_dir   <= 1'b0;
                        end else begin
                            score_left  <= score_left + 7'd1;
                            serve_dir   <= 1'b1;
                        end
                    end else if (let_now) begin
                        run_q       <= 1'b0;
                        ball_center <= 1'b1;
                        state       <= SERVE;
                    end else if (!pending && (miss_left ^ miss_right)) begin
                        pending   <= 1'b1;
                        pend_side <= miss_left ? SIDE_RIGHT : SIDE_LEFT;
                    end
                end
                POINT: begin
                    if (tmr_done) begin
                        if (win_any) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            blank     <= 1'b0;
                            winner    <= (score_right == WIN_TALLY) ? SIDE_RIGHT : SIDE_LEFT;
                        end else begin
                            state <= SERVE;
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        state       <= CLEAR;
                        game_over   <= 1'b0;
                        winner      <= 1'b0;
                        blank       <= 1'b0;
                        score_clear <= 1'b1;
                        score_right <= '0;
                        score_left  <= '0;
                    end else if (tmr_done) begin
                        blank <= ~blank;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Testbench for match_sequencer: randomized game play against a point-level
// game model, with score pulses checked by a decoupled scoreboard monitor.
module tb_match_sequencer;

    localparam int WIN = 3;
    localparam int SRV = 4;
    localparam int HLD = 5;
    localparam int BLK = 3;

    logic       clk;
    logic       reset;
    logic       frame;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       right_en;
    logic       left_en;
    logic       score_clear;
    logic       ball_run;
    logic       ball_center;
    logic       serve_dir;
    logic       game_over;
    logic       winner;
    logic       blank;
    logic [6:0] score_right;
    logic [6:0] score_left;

    match_sequencer #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SRV),
        .HOLD_FRAMES  (HLD),
        .BLINK_FRAMES (BLK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame       (frame),
        .start       (start),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .right_en    (right_en),
        .left_en     (left_en),
        .score_clear (score_clear),
        .ball_run    (ball_run),
        .ball_center (ball_center),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner),
        .blank       (blank),
        .score_right (score_right),
        .score_left  (score_left)
    );

    typedef struct {
        logic side;
        int   r;
        int   l;
    } exp_t;

    exp_t exq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_r_cnt = 0;
    int   en_l_cnt = 0;

    // Point-level game model
    int   ref_r = 0;
    int   ref_l = 0;
    int   tot_r = 0;
    int   tot_l = 0;
    logic ref_sd = 1'b0;
    logic ref_winner = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input logic f, input logic s, input logic ml, input logic mr, input logic rst);
        @(posedge clk);
        #1;
        frame      = f;
        start      = s;
        miss_left  = ml;
        miss_right = mr;
        reset      = rst;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 4)) idle();
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic model_clear();
        ref_r = 0;
        ref_l = 0;
    endtask

    // Serve delay: motion must start exactly one cycle after the last serve tick.
    task automatic serve_phase();
        frames(SRV);
        chk("run_before_serve_end", ball_run, 1'b0);
        idle();
        chk("run_after_serve", ball_run, 1'b1);
        chk("center_after_serve", ball_center, 1'b0);
    endtask

    task automatic start_game();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        serve_phase();
    endtask

    task automatic point_miss(input logic side, input logic force_extra);
        logic r;
        repeat ($urandom_range(1, 5)) idle();
        if (side) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        else      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (side) begin
            ref_r++; tot_r++; ref_sd = 1'b0;
            if (ref_r == WIN) ref_winner = 1'b1;
        end else begin
            ref_l++; tot_l++; ref_sd = 1'b1;
            if (ref_l == WIN) ref_winner = 1'b0;
        end
        exq.push_back('{side: side, r: ref_r, l: ref_l});
        if (force_extra || ($urandom_range(0, 1) == 1)) begin
            repeat ($urandom_range(1, 3)) idle();
            r = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'b0, r, ~r, 1'b0);
        end
        repeat ($urandom_range(0, 3)) idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_drops_on_point", ball_run, 1'b0);
        idle();
        chk("serve_dir", serve_dir, ref_sd);
        chk("center_in_point", ball_center, 1'b1);
    endtask

    task automatic finish_point();
        frames(HLD - 1);
        chk("no_over_during_hold", game_over, 1'b0);
        frames(1);
        idle();
        if (ref_r == WIN || ref_l == WIN) begin
            chk("game_over", game_over, 1'b1);
            chk("winner", winner, ref_winner);
            chk("blank_start", blank, 1'b0);
        end else begin
            chk("no_game_over", game_over, 1'b0);
            serve_phase();
        end
    endtask

    task automatic do_point(input logic side);
        point_miss(side, 1'b0);
        finish_point();
    endtask

    task automatic restart_from_over();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        model_clear();
        chk("clear_after_start", score_clear, 1'b1);
        chk("over_dropped", game_over, 1'b0);
        chk("blank_cleared", blank, 1'b0);
        chk("tally_r_zeroed", score_right, 0);
        chk("tally_l_zeroed", score_left, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_on_frame", score_clear, 1'b1);
        idle();
        chk("clear_released", score_clear, 1'b0);
        chk("idle_center", ball_center, 1'b1);
    endtask

    // Scoreboard monitor: every score pulse must match the oldest expected point.
    logic tally_due = 1'b0;
    int   due_r = 0;
    int   due_l = 0;
    always @(negedge clk) begin
        exp_t e;
        if (tally_due) begin
            tally_due = 1'b0;
            chk("tally_right", score_right, due_r);
            chk("tally_left", score_left, due_l);
        end
        if (right_en || left_en) begin
            if (right_en) en_r_cnt++;
            if (left_en)  en_l_cnt++;
            if (exq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_en: got right_en=%0d left_en=%0d, expected no pulse (cycle %0d)",
                         right_en, left_en, cyc);
            end else begin
                e = exq.pop_front();
                chk("en_side", {30'd0, right_en, left_en}, e.side ? 32'd2 : 32'd1);
                chk("en_in_frame", frame, 1'b1);
                due_r     = e.r;
                due_l     = e.l;
                tally_due = 1'b1;
            end
        end
    end

    initial begin
        int l_before;
        frame = 0; start = 0; miss_left = 0; miss_right = 0; reset = 1;

        // Reset and clear handshake
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_score_clear", score_clear, 1'b1);
        chk("rst_ball_center", ball_center, 1'b1);
        chk("rst_ball_run", ball_run, 1'b0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_serve_dir", serve_dir, 1'b0);
        chk("rst_tally_r", score_right, 0);
        chk("rst_tally_l", score_left, 0);
        while (cyc < 9) idle();
        chk("clear_held", score_clear, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_frame_cycle", score_clear, 1'b1);
        idle();
        chk("clear_released", score_clear, 1'b0);
        chk("idle_center", ball_center, 1'b1);
        chk("idle_run", ball_run, 1'b0);

        // Start is ignored unless it is a fresh rising edge in IDLE
        start_game();

        // Game 1: right scores with an ignored second miss, a let, then random play
        point_miss(1'b1, 1'b1);
        finish_point();
        repeat ($urandom_range(1, 5)) idle();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("let_run", ball_run, 1'b0);
        chk("let_center", ball_center, 1'b1);
        chk("let_tally_r", score_right, ref_r);
        chk("let_tally_l", score_left, ref_l);
        chk("let_serve_dir", serve_dir, ref_sd);
        serve_phase();
        while (ref_r < WIN && ref_l < WIN) do_point(1'($urandom_range(0, 1)));
        restart_from_over();
        start_game();

        // Game 2: left wins straight, then game-over blink timing
        l_before = en_l_cnt;
        repeat (WIN) do_point(1'b0);
        chk("left_pulse_count", en_l_cnt - l_before, WIN);
        frames(BLK - 1);
        chk("blank_before_toggle", blank, 1'b0);
        frames(1);
        chk("blank_on_tick", blank, 1'b0);
        idle();
        chk("blank_toggle_1", blank, 1'b1);
        frames(BLK);
        idle();
        chk("blank_toggle_2", blank, 1'b0);
        restart_from_over();
        start_game();

        // Reset with a pending point and a coincident frame must not score
        repeat ($urandom_range(1, 4)) idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat ($urandom_range(1, 3)) idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("no_en_in_reset", {31'd0, right_en | left_en}, 0);
        idle();
        model_clear();
        ref_sd = 1'b0;
        chk("rst_play_clear", score_clear, 1'b1);
        chk("rst_play_run", ball_run, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        start_game();
        frames(3);
        chk("still_playing", ball_run, 1'b1);

        // Reset in the middle of the point hold
        point_miss(1'b1, 1'b0);
        frames(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("no_en_mid_point_rst", {31'd0, right_en | left_en}, 0);
        idle();
        model_clear();
        ref_sd = 1'b0;
        chk("midpt_clear", score_clear, 1'b1);
        chk("midpt_center", ball_center, 1'b1);
        chk("midpt_run", ball_run, 1'b0);
        chk("midpt_tally_r", score_right, 0);
        chk("midpt_tally_l", score_left, 0);
        chk("midpt_serve_dir", serve_dir, 1'b0);
        chk("midpt_over", game_over, 1'b0);

        repeat (4) idle();
        chk("total_right_pulses", en_r_cnt, tot_r);
        chk("total_left_pulses", en_l_cnt, tot_l);
        chk("scoreboard_drained", exq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
